// File: rtl/mem_access_stage_if.sv
// Bundle of execute-side, data-memory and writeback signals around the memory stage.
// The stage uses the master modport; the surrounding pipeline/memory model uses slave.
interface mem_access_stage_if;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_alu_res;
   logic [31:0] ex_shift_res;
   logic        ex_res_sel;
   logic [31:0] ex_ea;
   logic [31:0] ex_dm_in;
   logic        ex_ovfalu;
   logic        ex_mem_rren;
   logic        ex_mem_wren;
   logic [1:0]  ex_size;
   logic        ex_unsigned;
   logic [4:0]  ex_cad;
   logic        ex_gp_we;

   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_cad;
   logic [31:0] wb_data;
   logic        wb_exc;
   logic [1:0]  wb_exc_cause;

   modport master (
      input  ex_valid, ex_alu_res, ex_shift_res, ex_res_sel, ex_ea, ex_dm_in, ex_ovfalu,
             ex_mem_rren, ex_mem_wren, ex_size, ex_unsigned, ex_cad, ex_gp_we,
             dm_ack, dm_rdata,
      output ex_ready, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
             wb_valid, wb_we, wb_cad, wb_data, wb_exc, wb_exc_cause
   );

   modport slave (
      output ex_valid, ex_alu_res, ex_shift_res, ex_res_sel, ex_ea, ex_dm_in, ex_ovfalu,
             ex_mem_rren, ex_mem_wren, ex_size, ex_unsigned, ex_cad, ex_gp_we,
             dm_ack, dm_rdata,
      input  ex_ready, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
             wb_valid, wb_we, wb_cad, wb_data, wb_exc, wb_exc_cause
   );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: latches one execute result, runs a big-endian load/store over a req/ack port,
// and emits one writeback packet per op. Define MEM_TIMEOUT_EN to add a dm_ack timeout (bus error).
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic               clk,
   input  logic               reset,
   mem_access_stage_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t state_reg, state_next;

   logic        accept;
   logic        is_mem, illegal, misaligned, ovf, exc_any, mem_go;
   logic [1:0]  cause_in;
   logic [3:0]  be_in;
   logic [31:0] wdata_in;
   logic        mem_done, timeout_hit, fire;

   logic [4:0]  cad_reg;
   logic        gp_we_reg, rren_reg, wren_reg, uns_reg, exc_reg, mem_reg;
   logic [1:0]  size_reg, lane_reg, cause_reg;
   logic [31:0] res_reg;

   logic [7:0]  rd_byte [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;

   logic        dm_req_reg, dm_we_reg;
   logic [31:0] dm_addr_reg, dm_wdata_reg;
   logic [3:0]  dm_be_reg;
   logic        wb_valid_reg, wb_we_reg, wb_exc_reg;
   logic [4:0]  wb_cad_reg;
   logic [31:0] wb_data_reg;
   logic [1:0]  wb_cause_reg;

   assign accept = bus.ex_valid && (state_reg == IDLE);

   // Accept-time decode; illegal beats misaligned beats overflow.
   always_comb begin
      is_mem     = bus.ex_mem_rren | bus.ex_mem_wren;
      illegal    = (bus.ex_mem_rren & bus.ex_mem_wren) | (is_mem & (bus.ex_size == 2'b11));
      misaligned = is_mem & (((bus.ex_size == 2'b01) & bus.ex_ea[0]) |
                             ((bus.ex_size == 2'b10) & (bus.ex_ea[1:0] != 2'b00)));
      ovf        = ~is_mem & bus.ex_ovfalu;
      exc_any    = illegal | misaligned | ovf;
      mem_go     = is_mem & ~exc_any;
      cause_in   = 2'b00;
      if (illegal)         cause_in = 2'b11;
      else if (misaligned) cause_in = 2'b01;
      else if (ovf)        cause_in = 2'b10;

      be_in    = 4'b0000;
      wdata_in = bus.ex_dm_in;
      case (bus.ex_size)
         2'b00: begin
            be_in    = 4'b1000 >> bus.ex_ea[1:0];
            wdata_in = {4{bus.ex_dm_in[7:0]}};
         end
         2'b01: begin
            be_in    = bus.ex_ea[1] ? 4'b0011 : 4'b1100;
            wdata_in = {2{bus.ex_dm_in[15:0]}};
         end
         2'b10:   be_in = 4'b1111;
         default: be_in = 4'b0000;
      endcase
   end

   // Byte lane gi of the read word; lane 0 is the most significant byte.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = bus.dm_rdata[31-8*gi -: 8];
   end

   assign byte_sel = rd_byte[lane_reg];
   assign half_sel = lane_reg[1] ? bus.dm_rdata[15:0] : bus.dm_rdata[31:16];

   always_comb begin
      load_val = bus.dm_rdata;
      case (size_reg)
         2'b00:   load_val = uns_reg ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_val = uns_reg ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_val = bus.dm_rdata;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   logic [CNT_W-1:0] count_reg;

   assign timeout_hit = (state_reg == REQ) && !bus.dm_ack && (count_reg == CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (accept && mem_go) begin
         count_reg <= '0;
      end else if ((state_reg == REQ) && !bus.dm_ack) begin
         count_reg <= count_reg + 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg  = (TIMEOUT_CYCLES == CNT_W);
   assign timeout_hit = 1'b0;
`endif

   assign mem_done = (state_reg == REQ) && (bus.dm_ack || timeout_hit);
   // Memory ops write back straight off the ack edge; RESP is then just the visible pulse cycle.
   assign fire     = mem_done || ((state_reg == RESP) && !mem_reg);

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = mem_go ? REQ : RESP;
         REQ:     if (mem_done) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cad_reg      <= '0;
         gp_we_reg    <= 1'b0;
         rren_reg     <= 1'b0;
         wren_reg     <= 1'b0;
         uns_reg      <= 1'b0;
         exc_reg      <= 1'b0;
         mem_reg      <= 1'b0;
         size_reg     <= '0;
         lane_reg     <= '0;
         cause_reg    <= '0;
         res_reg      <= '0;
         dm_req_reg   <= 1'b0;
         dm_we_reg    <= 1'b0;
         dm_addr_reg  <= '0;
         dm_be_reg    <= '0;
         dm_wdata_reg <= '0;
         wb_valid_reg <= 1'b0;
         wb_we_reg    <= 1'b0;
         wb_exc_reg   <= 1'b0;
         wb_cad_reg   <= '0;
         wb_data_reg  <= '0;
         wb_cause_reg <= '0;
      end else begin
         wb_valid_reg <= fire;
         if (accept) begin
            cad_reg   <= bus.ex_cad;
            gp_we_reg <= bus.ex_gp_we;
            rren_reg  <= bus.ex_mem_rren;
            wren_reg  <= bus.ex_mem_wren;
            uns_reg   <= bus.ex_unsigned;
            exc_reg   <= exc_any;
            mem_reg   <= mem_go;
            size_reg  <= bus.ex_size;
            lane_reg  <= bus.ex_ea[1:0];
            cause_reg <= cause_in;
            res_reg   <= bus.ex_res_sel ? bus.ex_shift_res : bus.ex_alu_res;
            if (mem_go) begin
               dm_req_reg   <= 1'b1;
               dm_we_reg    <= bus.ex_mem_wren;
               dm_addr_reg  <= {bus.ex_ea[31:2], 2'b00};
               dm_be_reg    <= be_in;
               dm_wdata_reg <= wdata_in;
            end
         end
         if (mem_done) dm_req_reg <= 1'b0;
         if (fire) begin
            wb_cad_reg <= cad_reg;
            if (timeout_hit) begin
               wb_exc_reg   <= 1'b1;
               wb_cause_reg <= 2'b11;
               wb_we_reg    <= 1'b0;
               wb_data_reg  <= res_reg;
            end else begin
               wb_exc_reg   <= exc_reg;
               wb_cause_reg <= cause_reg;
               wb_we_reg    <= gp_we_reg & ~exc_reg & ~wren_reg;
               wb_data_reg  <= (mem_done && rren_reg) ? load_val : res_reg;
            end
         end
      end
   end

   assign bus.ex_ready     = (state_reg == IDLE);
   assign bus.dm_req       = dm_req_reg;
   assign bus.dm_we        = dm_we_reg;
   assign bus.dm_addr      = dm_addr_reg;
   assign bus.dm_be        = dm_be_reg;
   assign bus.dm_wdata     = dm_wdata_reg;
   assign bus.wb_valid     = wb_valid_reg;
   assign bus.wb_we        = wb_we_reg;
   assign bus.wb_cad       = wb_cad_reg;
   assign bus.wb_data      = wb_data_reg;
   assign bus.wb_exc       = wb_exc_reg;
   assign bus.wb_exc_cause = wb_cause_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expected writeback packets,
// a negedge monitor pops and compares each wb_valid pulse. Timeout vector needs MEM_TIMEOUT_EN.
module tb_mem_access_stage;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   req_cnt = 0;

   typedef struct {
      logic [4:0]  cad;
      logic [31:0] data;
      logic        chk_data;
      logic        we;
      logic        exc;
      logic [1:0]  cause;
      int          at_cyc;
   } exp_t;

   exp_t sb[$];

   mem_access_stage_if bus();

   mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.dm_req === 1'b1) req_cnt <= req_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: each wb_valid pulse must match the oldest expected packet.
   always @(negedge clk) begin
      if (bus.wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_cad", 32'(bus.wb_cad), 32'(e.cad));
            chk("wb_we", 32'(bus.wb_we), 32'(e.we));
            chk("wb_exc", 32'(bus.wb_exc), 32'(e.exc));
            chk("wb_exc_cause", 32'(bus.wb_exc_cause), 32'(e.cause));
            if (e.chk_data) chk("wb_data", bus.wb_data, e.data);
            if (e.at_cyc >= 0) chk("wb_latency", 32'(cyc), 32'(e.at_cyc));
         end
      end
   end

   task automatic push_exp(input logic [4:0] cad, input logic [31:0] data, input logic chk_data,
                           input logic we, input logic exc, input logic [1:0] cause, input int at_cyc);
      exp_t e;
      e.cad = cad; e.data = data; e.chk_data = chk_data;
      e.we = we; e.exc = exc; e.cause = cause; e.at_cyc = at_cyc;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [31:0] alu, input logic [31:0] shift, input logic sel,
                        input logic [31:0] ea, input logic [31:0] din, input logic ovf,
                        input logic rr, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [4:0] cad, input logic gpwe, output int tcyc);
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.ex_ready === 1'b1) begin ok = 1; break; end
      end
      if (!ok) chk("ex_ready_wait", 32'd0, 32'd1);
      @(posedge clk); #1;
      bus.ex_alu_res = alu; bus.ex_shift_res = shift; bus.ex_res_sel = sel;
      bus.ex_ea = ea; bus.ex_dm_in = din; bus.ex_ovfalu = ovf;
      bus.ex_mem_rren = rr; bus.ex_mem_wren = wr; bus.ex_size = size;
      bus.ex_unsigned = uns; bus.ex_cad = cad; bus.ex_gp_we = gpwe;
      bus.ex_valid = 1'b1;
      tcyc = cyc;
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.dm_req === 1'b1) begin ok = 1; break; end
      end
      if (!ok) chk("dm_req_wait", 32'd0, 32'd1);
   endtask

   // Memory model: checks the request, holds it for dly cycles, then acks one cycle.
   task automatic mem_resp(input int dly, input logic [31:0] rdata, input logic [31:0] addr,
                           input logic [3:0] be, input logic we, input logic [31:0] wdata,
                           input logic chk_wdata);
      bit ok;
      exp_t e;
      wait_req(ok);
      if (ok) begin
         chk("dm_addr", bus.dm_addr, addr);
         chk("dm_be", 32'(bus.dm_be), 32'(be));
         chk("dm_we", 32'(bus.dm_we), 32'(we));
         if (chk_wdata) chk("dm_wdata", bus.dm_wdata, wdata);
         for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("dm_req_held", 32'(bus.dm_req), 32'd1);
         end
         @(posedge clk); #1;
         bus.dm_ack = 1'b1; bus.dm_rdata = rdata;
         e = sb.pop_back();
         e.at_cyc = cyc + 1;
         sb.push_back(e);
         @(posedge clk); #1;
         bus.dm_ack = 1'b0; bus.dm_rdata = 32'hx;
         @(negedge clk);
         chk("dm_req_drop", 32'(bus.dm_req), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  t;
      int  r0;
      bit  ok;
      bus.ex_valid = 0; bus.ex_alu_res = 0; bus.ex_shift_res = 0; bus.ex_res_sel = 0;
      bus.ex_ea = 0; bus.ex_dm_in = 0; bus.ex_ovfalu = 0; bus.ex_mem_rren = 0;
      bus.ex_mem_wren = 0; bus.ex_size = 0; bus.ex_unsigned = 0; bus.ex_cad = 0;
      bus.ex_gp_we = 0; bus.dm_ack = 0; bus.dm_rdata = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
      chk("rst_dm_req", 32'(bus.dm_req), 32'd0);
      chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("rst_dm_addr", bus.dm_addr, 32'd0);
      chk("rst_wb_data", bus.wb_data, 32'd0);
      chk("rst_wb_cause", 32'(bus.wb_exc_cause), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // ALU op, then shift-select op issued back to back
      r0 = req_cnt;
      issue(32'h5, 32'h77, 0, 32'h0, 32'h0, 0, 0, 0, 2'b10, 0, 5'd8, 1, t);
      push_exp(5'd8, 32'h5, 1, 1, 0, 2'b00, t + 2);
      issue(32'h1, 32'h8000_0000, 1, 32'h0, 32'h0, 0, 0, 0, 2'b10, 0, 5'd3, 1, t);
      push_exp(5'd3, 32'h8000_0000, 1, 1, 0, 2'b00, t + 2);

      // Exceptions: misaligned word, overflow, rren&wren, size 11, misaligned half
      issue(32'h0, 32'h0, 0, 32'h3002, 32'h0, 0, 1, 0, 2'b10, 0, 5'd11, 1, t);
      push_exp(5'd11, 32'h0, 0, 0, 1, 2'b01, t + 2);
      issue(32'h7FFF_FFFF, 32'h0, 0, 32'h0, 32'h0, 1, 0, 0, 2'b10, 0, 5'd12, 1, t);
      push_exp(5'd12, 32'h0, 0, 0, 1, 2'b10, t + 2);
      issue(32'h0, 32'h0, 0, 32'h100, 32'h0, 0, 1, 1, 2'b10, 0, 5'd13, 1, t);
      push_exp(5'd13, 32'h0, 0, 0, 1, 2'b11, t + 2);
      issue(32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 0, 2'b11, 0, 5'd14, 1, t);
      push_exp(5'd14, 32'h0, 0, 0, 1, 2'b11, t + 2);
      issue(32'h0, 32'h0, 0, 32'h5001, 32'h0, 0, 1, 0, 2'b01, 0, 5'd15, 1, t);
      push_exp(5'd15, 32'h0, 0, 0, 1, 2'b01, t + 2);
      repeat (3) @(negedge clk);
      chk("no_dm_req_nonmem", 32'(req_cnt), 32'(r0));

      // Loads
      issue(32'h1001, 32'h0, 0, 32'h1001, 32'h0, 0, 1, 0, 2'b00, 0, 5'd9, 1, t);
      push_exp(5'd9, 32'hFFFF_FF80, 1, 1, 0, 2'b00, -1);
      mem_resp(3, 32'h1180_FF22, 32'h1000, 4'b0100, 0, 32'h0, 0);
      issue(32'h1001, 32'h0, 0, 32'h1001, 32'h0, 0, 1, 0, 2'b00, 1, 5'd10, 1, t);
      push_exp(5'd10, 32'h0000_0080, 1, 1, 0, 2'b00, -1);
      mem_resp(3, 32'h1180_FF22, 32'h1000, 4'b0100, 0, 32'h0, 0);
      issue(32'h0, 32'h0, 0, 32'h5002, 32'h0, 0, 1, 0, 2'b01, 0, 5'd16, 1, t);
      push_exp(5'd16, 32'hFFFF_8765, 1, 1, 0, 2'b00, -1);
      mem_resp(1, 32'h1234_8765, 32'h5000, 4'b0011, 0, 32'h0, 0);
      issue(32'h0, 32'h0, 0, 32'h5000, 32'h0, 0, 1, 0, 2'b01, 1, 5'd17, 1, t);
      push_exp(5'd17, 32'h0000_8765, 1, 1, 0, 2'b00, -1);
      mem_resp(0, 32'h8765_1234, 32'h5000, 4'b1100, 0, 32'h0, 0);
      issue(32'h0, 32'h0, 0, 32'h7000, 32'h0, 0, 1, 0, 2'b10, 0, 5'd18, 1, t);
      push_exp(5'd18, 32'hDEAD_BEEF, 1, 1, 0, 2'b00, -1);
      mem_resp(0, 32'hDEAD_BEEF, 32'h7000, 4'b1111, 0, 32'h0, 0);

      // Stores (gp_we set on purpose: wb_we must still be 0)
      issue(32'h0, 32'h0, 0, 32'h2002, 32'hAAAA_BEEF, 0, 0, 1, 2'b01, 0, 5'd0, 1, t);
      push_exp(5'd0, 32'h0, 0, 0, 0, 2'b00, -1);
      mem_resp(3, 32'h0, 32'h2000, 4'b0011, 1, 32'hBEEF_BEEF, 1);
      issue(32'h0, 32'h0, 0, 32'h6003, 32'h0000_00A5, 0, 0, 1, 2'b00, 0, 5'd0, 1, t);
      push_exp(5'd0, 32'h0, 0, 0, 0, 2'b00, -1);
      mem_resp(2, 32'h0, 32'h6000, 4'b0001, 1, 32'hA5A5_A5A5, 1);
      issue(32'h0, 32'h0, 0, 32'h7004, 32'h0123_4567, 0, 0, 1, 2'b10, 0, 5'd0, 1, t);
      push_exp(5'd0, 32'h0, 0, 0, 0, 2'b00, -1);
      mem_resp(0, 32'h0, 32'h7004, 4'b1111, 1, 32'h0123_4567, 1);

      // Reset during REQ: aborted op produces nothing, late ack ignored
      issue(32'h0, 32'h0, 0, 32'h4000, 32'h0, 0, 1, 0, 2'b10, 0, 5'd20, 1, t);
      wait_req(ok);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_dm_req", 32'(bus.dm_req), 32'd0);
      chk("rst_mid_ex_ready", 32'(bus.ex_ready), 32'd1);
      @(posedge clk); #1 bus.dm_ack = 1'b1; bus.dm_rdata = 32'h1111_1111;
      @(negedge clk);
      chk("late_ack_ex_ready", 32'(bus.ex_ready), 32'd1);
      @(posedge clk); #1 bus.dm_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("late_ack_dm_req", 32'(bus.dm_req), 32'd0);
      issue(32'h0000_ABCD, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 2'b10, 0, 5'd21, 1, t);
      push_exp(5'd21, 32'h0000_ABCD, 1, 1, 0, 2'b00, t + 2);

`ifdef MEM_TIMEOUT_EN
      // No ack: REQ lasts TIMEOUT_CYCLES+1 = 5 cycles, then bus error
      issue(32'h0, 32'h0, 0, 32'h8000, 32'h0, 0, 1, 0, 2'b10, 0, 5'd22, 1, t);
      push_exp(5'd22, 32'h0, 0, 0, 1, 2'b11, -1);
      r0 = 0;
      wait_req(ok);
      if (ok) begin
         r0 = 1;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.dm_req !== 1'b1) break;
            r0++;
         end
      end
      chk("timeout_req_cycles", 32'(r0), 32'd5);
`endif

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
